apb_reg_slice: RTL and testbench
================================

Name: apb_reg_slice

Overview:
- Registered APB4 slave-to-master bridge and the parametrised successor of the combinational APB feed-through.
- Cuts every combinational path between the upstream APB slave port and the downstream APB master port, for timing closure across long routes or hierarchy boundaries.
- Generalises address/data width and adds PSTRB/PPROT pass-through.
- Adds an optional access timeout that returns PSLVERR when the downstream slave never asserts PREADY.

Parameters:
ADDR_W, 32, address width of both ports
DATA_W, 32, data width of both ports; legal values 8, 16, 32, 64
TIMEOUT, 0, downstream access-phase cycle limit before forced error; 0 disables the timeout

Ports:
PCLK  in  1  clock for both ports
PRESETn  in  1  asynchronous active-low reset
S_PSELx  in  1  upstream select
S_PENABLE  in  1  upstream enable
S_PADDR  in  ADDR_W  upstream address
S_PWDATA  in  DATA_W  upstream write data
S_PWRITE  in  1  upstream direction, 1 = write
S_PSTRB  in  DATA_W/8  upstream byte strobes
S_PPROT  in  3  upstream protection
S_PRDATA  out  DATA_W  upstream read data, registered
S_PREADY  out  1  upstream ready, registered
S_PSLVERR  out  1  upstream error, registered
M_PSELx  out  1  downstream select, registered
M_PENABLE  out  1  downstream enable, registered
M_PADDR  out  ADDR_W  downstream address, registered
M_PWDATA  out  DATA_W  downstream write data, registered
M_PWRITE  out  1  downstream direction, registered
M_PSTRB  out  DATA_W/8  downstream strobes, registered
M_PPROT  out  3  downstream protection, registered
M_PRDATA  in  DATA_W  downstream read data
M_PREADY  in  1  downstream ready
M_PSLVERR  in  1  downstream error

Behaviour:
- Reset: all outputs 0; FSM in IDLE; timeout counter 0. Reset is asynchronous and takes effect mid-transfer with no completion or response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Start condition: S_PSELx=1 and S_PENABLE=0.
  - On start, capture PADDR/PWDATA/PWRITE/PSTRB/PPROT into the M_* registers and go to SETUP.
  - S_PENABLE=1 seen in IDLE (no setup phase) is ignored.
- SETUP: M_PSELx=1, M_PENABLE=0 for exactly one cycle, then go to ACCESS.
- ACCESS: M_PSELx=1, M_PENABLE=1.
  - On M_PREADY=1: capture M_PRDATA (reads only; writes capture 0) and M_PSLVERR, then go to RESP.
  - Timeout: when TIMEOUT>0 and the count of ACCESS cycles without M_PREADY reaches TIMEOUT, set captured PRDATA=0 and PSLVERR=1, go to RESP. Counter width is $clog2(TIMEOUT+1). The counter clears on entry to ACCESS.
- RESP: M_PSELx=0, M_PENABLE=0. S_PREADY=1 for exactly one cycle with captured S_PRDATA/S_PSLVERR, then go to IDLE.
- Outside RESP, S_PREADY=0, S_PRDATA=0 and S_PSLVERR=0.
- M_PADDR/M_PWDATA/M_PWRITE/M_PSTRB/M_PPROT hold their last value outside an active transfer; they change only on capture.
- Latency, with downstream zero-wait:
  - Upstream setup at cycle 0.
  - M_PSELx rises at cycle 1; M_PENABLE at cycle 2; M_PREADY sampled at cycle 2.
  - S_PREADY=1 at cycle 3.
  - Total: 3 upstream access-phase cycles per zero-wait transfer. Each downstream wait state adds one cycle.
- Back-to-back transfers: a new upstream setup may occur in the cycle after RESP. IDLE samples it; the minimum spacing is one IDLE cycle.
- Upstream drops S_PSELx before S_PREADY (protocol violation):
  - The downstream transfer still completes, or times out.
  - RESP still occurs for one cycle with S_PREADY=1; the response is discarded.
  - The FSM returns to IDLE. No new capture happens before RESP.
- Upstream inputs are sampled only at capture in IDLE. Changes in S_* during SETUP/ACCESS/RESP have no effect.
- TIMEOUT=0: the FSM waits in ACCESS indefinitely and no counter logic is synthesised.

Decomposition:
- Shared package apb_pkg holds:
  - FSM state encoding localparams: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3.
  - PPROT width constant: 3.
  - The DATA_W legality check.
- Single flat module. The timeout counter is under 15 lines, so a separate sub-module is not warranted.

Test Plan:
- Zero-wait write: ADDR 0x0000_0010, WDATA 0xDEAD_BEEF, PSTRB 4'hF, PPROT 3'b010 -> M_* carries identical values. M_PSELx rises 1 cycle after upstream setup. S_PREADY=1 exactly 3 cycles after setup, S_PSLVERR=0.
- Read with 2 downstream wait states, M_PRDATA=0x1234_5678 -> S_PREADY rises 5 cycles after setup, S_PRDATA=0x1234_5678, S_PRDATA=0 on all other cycles.
- Timeout with TIMEOUT=4 and M_PREADY held 0 -> M_PENABLE high 4 cycles then M_PSELx=0. S_PREADY=1 with S_PSLVERR=1 and S_PRDATA=0. FSM back in IDLE.
- Downstream error: M_PSLVERR=1 with M_PREADY=1 on a write -> S_PSLVERR=1 in the RESP cycle only.
- Back-to-back: two reads to 0x4 and 0x8 with no upstream idle cycle between them -> two separate downstream transfers, addresses in order, each response on its own S_PREADY pulse.
- Reset mid-transfer: PRESETn low during ACCESS -> all outputs 0 immediately, asynchronously. After release, the next upstream setup starts a clean transfer.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, PPROT width and DATA_W legality.
package apb_pkg;

  localparam int unsigned PPROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Only byte-multiple bus widths of 8..64 bits are supported.
  function automatic bit data_w_legal(input int unsigned w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/apb_reg_slice.sv
// Registered APB4 bridge: upstream slave port to downstream master port with
// every output flopped, byte-strobe/protection pass-through and an optional
// access-phase timeout that forces PSLVERR.
module apb_reg_slice
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                S_PSELx,
  input  logic                S_PENABLE,
  input  logic [ADDR_W-1:0]   S_PADDR,
  input  logic [DATA_W-1:0]   S_PWDATA,
  input  logic                S_PWRITE,
  input  logic [DATA_W/8-1:0] S_PSTRB,
  input  logic [PPROT_W-1:0]  S_PPROT,
  output logic [DATA_W-1:0]   S_PRDATA,
  output logic                S_PREADY,
  output logic                S_PSLVERR,
  output logic                M_PSELx,
  output logic                M_PENABLE,
  output logic [ADDR_W-1:0]   M_PADDR,
  output logic [DATA_W-1:0]   M_PWDATA,
  output logic                M_PWRITE,
  output logic [DATA_W/8-1:0] M_PSTRB,
  output logic [PPROT_W-1:0]  M_PPROT,
  input  logic [DATA_W-1:0]   M_PRDATA,
  input  logic                M_PREADY,
  input  logic                M_PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;

  // Reject unsupported data widths at elaboration.
  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("apb_reg_slice: DATA_W must be 8, 16, 32 or 64");
  end

  state_t              state;
  state_t              state_n;
  logic                timeout_hit_c;

  logic                m_psel_n;
  logic                m_penable_n;
  logic [ADDR_W-1:0]   m_paddr_n;
  logic [DATA_W-1:0]   m_pwdata_n;
  logic                m_pwrite_n;
  logic [STRB_W-1:0]   m_pstrb_n;
  logic [PPROT_W-1:0]  m_pprot_n;
  logic [DATA_W-1:0]   s_prdata_n;
  logic                s_pready_n;
  logic                s_pslverr_n;

  // Access-phase timeout counter; absent entirely when TIMEOUT is 0.
  if (TIMEOUT > 0) begin : g_timeout
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Count ACCESS cycles without PREADY; cleared while in SETUP so every access starts at 0.
    always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
        cnt <= '0;
      end else if (state == SETUP) begin
        cnt <= '0;
      end else if ((state == ACCESS) && !M_PREADY) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign timeout_hit_c = (state == ACCESS) && !M_PREADY && (cnt == CNT_W'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_hit_c = 1'b0;
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n     = state;
    m_psel_n    = 1'b0;
    m_penable_n = 1'b0;
    m_paddr_n   = M_PADDR;
    m_pwdata_n  = M_PWDATA;
    m_pwrite_n  = M_PWRITE;
    m_pstrb_n   = M_PSTRB;
    m_pprot_n   = M_PPROT;
    s_prdata_n  = '0;
    s_pready_n  = 1'b0;
    s_pslverr_n = 1'b0;

    case (state)
      IDLE: begin
        // Only a proper setup phase starts a transfer; a bare PENABLE is ignored.
        if (S_PSELx && !S_PENABLE) begin
          state_n    = SETUP;
          m_psel_n   = 1'b1;
          m_paddr_n  = S_PADDR;
          m_pwdata_n = S_PWDATA;
          m_pwrite_n = S_PWRITE;
          m_pstrb_n  = S_PSTRB;
          m_pprot_n  = S_PPROT;
        end
      end
      SETUP: begin
        state_n     = ACCESS;
        m_psel_n    = 1'b1;
        m_penable_n = 1'b1;
      end
      ACCESS: begin
        if (M_PREADY) begin
          state_n     = RESP;
          s_pready_n  = 1'b1;
          s_prdata_n  = M_PWRITE ? '0 : M_PRDATA;
          s_pslverr_n = M_PSLVERR;
        end else if (timeout_hit_c) begin
          state_n     = RESP;
          s_pready_n  = 1'b1;
          s_pslverr_n = 1'b1;
        end else begin
          m_psel_n    = 1'b1;
          m_penable_n = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      M_PSELx   <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PADDR   <= '0;
      M_PWDATA  <= '0;
      M_PWRITE  <= 1'b0;
      M_PSTRB   <= '0;
      M_PPROT   <= '0;
      S_PRDATA  <= '0;
      S_PREADY  <= 1'b0;
      S_PSLVERR <= 1'b0;
    end else begin
      M_PSELx   <= m_psel_n;
      M_PENABLE <= m_penable_n;
      M_PADDR   <= m_paddr_n;
      M_PWDATA  <= m_pwdata_n;
      M_PWRITE  <= m_pwrite_n;
      M_PSTRB   <= m_pstrb_n;
      M_PPROT   <= m_pprot_n;
      S_PRDATA  <= s_prdata_n;
      S_PREADY  <= s_pready_n;
      S_PSLVERR <= s_pslverr_n;
    end
  end

endmodule

// File: tb/tb_apb_reg_slice.sv
// Directed bench for apb_reg_slice with a scoreboard of expected responses.
module tb_apb_reg_slice;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TMO    = 4;

  logic              PCLK;
  logic              PRESETn;
  logic              S_PSELx;
  logic              S_PENABLE;
  logic [31:0]       S_PADDR;
  logic [31:0]       S_PWDATA;
  logic              S_PWRITE;
  logic [3:0]        S_PSTRB;
  logic [2:0]        S_PPROT;
  logic [31:0]       S_PRDATA;
  logic              S_PREADY;
  logic              S_PSLVERR;
  logic              M_PSELx;
  logic              M_PENABLE;
  logic [31:0]       M_PADDR;
  logic [31:0]       M_PWDATA;
  logic              M_PWRITE;
  logic [3:0]        M_PSTRB;
  logic [2:0]        M_PPROT;
  logic [31:0]       M_PRDATA;
  logic              M_PREADY;
  logic              M_PSLVERR;

  // Downstream slave model configuration.
  logic [31:0] rdata_cfg;
  logic        err_cfg;
  int          wait_cfg;
  logic        hang_cfg;
  int          acc_cnt;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          pen;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  apb_reg_slice #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PADDR(S_PADDR),
    .S_PWDATA(S_PWDATA), .S_PWRITE(S_PWRITE), .S_PSTRB(S_PSTRB),
    .S_PPROT(S_PPROT), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .S_PSLVERR(S_PSLVERR), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PWRITE(M_PWRITE),
    .M_PSTRB(M_PSTRB), .M_PPROT(M_PPROT), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave: ready after wait_cfg access cycles unless hung.
  always @(posedge PCLK) acc_cnt <= (M_PSELx && M_PENABLE) ? acc_cnt + 1 : 0;
  assign M_PREADY  = M_PSELx && M_PENABLE && !hang_cfg && (acc_cnt == wait_cfg);
  assign M_PRDATA  = rdata_cfg;
  assign M_PSLVERR = err_cfg && M_PREADY;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One upstream transfer; returns after sampling the S_PREADY cycle so a
  // following call issues its setup in the very next cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] rdat, input logic err, input int waits,
                      input logic hang);
    exp_t e;
    exp_t got;
    int   cyc;
    int   pen;
    bit   done;
    e.rdata = (wr || hang) ? 32'h0 : rdat;
    e.err   = hang ? 1'b1 : err;
    e.lat   = hang ? 2 + int'(TMO) : 3 + waits;
    e.pen   = hang ? int'(TMO) : waits + 1;
    sb.push_back(e);
    @(posedge PCLK) #1;
    rdata_cfg = rdat; err_cfg = err; wait_cfg = waits; hang_cfg = hang;
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PADDR = addr; S_PWDATA = wdata;
    S_PWRITE = wr; S_PSTRB = strb; S_PPROT = prot;
    @(negedge PCLK);
    check("m_psel_cycle0", 64'(M_PSELx), 64'(0));
    @(posedge PCLK) #1;
    S_PENABLE = 1'b1;
    cyc = 1; pen = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge PCLK);
      if (cyc == 1) begin
        check("m_psel_cycle1", 64'(M_PSELx), 64'(1));
        check("m_penable_cycle1", 64'(M_PENABLE), 64'(0));
        check("m_paddr", 64'(M_PADDR), 64'(addr));
        check("m_pwdata", 64'(M_PWDATA), 64'(wdata));
        check("m_pwrite", 64'(M_PWRITE), 64'(wr));
        check("m_pstrb", 64'(M_PSTRB), 64'(strb));
        check("m_pprot", 64'(M_PPROT), 64'(prot));
      end
      if (M_PENABLE) pen++;
      if (S_PREADY) begin
        done = 1;
        if (sb.size() == 0) begin
          tests++; fails++;
          $error("FAIL sb_empty observed=response expected=none");
        end else begin
          got = sb.pop_front();
          check("latency", 64'(cyc), 64'(got.lat));
          check("penable_cycles", 64'(pen), 64'(got.pen));
          check("s_prdata", 64'(S_PRDATA), 64'(got.rdata));
          check("s_pslverr", 64'(S_PSLVERR), 64'(got.err));
          check("m_psel_resp", 64'(M_PSELx), 64'(0));
        end
      end else begin
        check("s_prdata_quiet", 64'(S_PRDATA), 64'(0));
        check("s_pslverr_quiet", 64'(S_PSLVERR), 64'(0));
        @(posedge PCLK) #1;
        cyc++;
      end
    end
    if (!done) begin
      tests++; fails++;
      $error("FAIL ready_wait observed=no_pready expected=pready_within_40");
    end
  endtask

  // Drop the upstream select and confirm the bridge is idle.
  task automatic go_idle();
    @(posedge PCLK) #1;
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
    @(negedge PCLK);
    check("idle_pready", 64'(S_PREADY), 64'(0));
    check("idle_pslverr", 64'(S_PSLVERR), 64'(0));
    check("idle_prdata", 64'(S_PRDATA), 64'(0));
    check("idle_psel", 64'(M_PSELx), 64'(0));
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0; fails = 0;
    PRESETn = 1'b0;
    S_PSELx = 0; S_PENABLE = 0; S_PADDR = '0; S_PWDATA = '0;
    S_PWRITE = 0; S_PSTRB = '0; S_PPROT = '0;
    rdata_cfg = '0; err_cfg = 0; wait_cfg = 0; hang_cfg = 0;
    #12;
    check("rst_m_psel", 64'(M_PSELx), 64'(0));
    check("rst_m_paddr", 64'(M_PADDR), 64'(0));
    check("rst_s_pready", 64'(S_PREADY), 64'(0));
    check("rst_s_prdata", 64'(S_PRDATA), 64'(0));
    @(posedge PCLK) #1;
    PRESETn = 1'b1;

    // Zero-wait write; slave drives nonzero PRDATA that must not leak through.
    xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 32'hAAAA_5555, 1'b0, 0, 1'b0);
    go_idle();

    // Read with two downstream wait states.
    xfer(1'b0, 32'h0000_0020, 32'h0, 4'h0, 3'b000, 32'h1234_5678, 1'b0, 2, 1'b0);
    go_idle();

    // Timeout: slave never ready.
    xfer(1'b0, 32'h0000_0030, 32'h0, 4'h0, 3'b001, 32'hFFFF_FFFF, 1'b0, 0, 1'b1);
    go_idle();

    // Downstream error on a write.
    xfer(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'h3, 3'b100, 32'h0, 1'b1, 0, 1'b0);
    go_idle();

    // Back-to-back reads with no upstream idle cycle.
    xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3'b000, 32'h0000_0A04, 1'b0, 0, 1'b0);
    xfer(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'b000, 32'h0000_0A08, 1'b0, 1, 1'b0);
    go_idle();

    // PENABLE without a setup phase is ignored.
    @(posedge PCLK) #1;
    S_PSELx = 1'b1; S_PENABLE = 1'b1; S_PADDR = 32'h0000_0050;
    @(posedge PCLK) #1;
    @(negedge PCLK);
    check("no_setup_psel", 64'(M_PSELx), 64'(0));
    check("no_setup_paddr_held", 64'(M_PADDR), 64'(32'h0000_0008));
    go_idle();

    // Reset asserted during ACCESS clears all outputs at once.
    @(posedge PCLK) #1;
    hang_cfg = 1'b1;
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PADDR = 32'h0000_0060;
    S_PWDATA = 32'hCAFE_0001; S_PWRITE = 1'b1; S_PSTRB = 4'hF; S_PPROT = 3'b111;
    @(posedge PCLK) #1;
    S_PENABLE = 1'b1;
    @(posedge PCLK) #1;
    @(negedge PCLK);
    check("pre_rst_penable", 64'(M_PENABLE), 64'(1));
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_rst_psel", 64'(M_PSELx), 64'(0));
    check("async_rst_penable", 64'(M_PENABLE), 64'(0));
    check("async_rst_paddr", 64'(M_PADDR), 64'(0));
    check("async_rst_pwdata", 64'(M_PWDATA), 64'(0));
    check("async_rst_pwrite", 64'(M_PWRITE), 64'(0));
    check("async_rst_pstrb", 64'(M_PSTRB), 64'(0));
    check("async_rst_pprot", 64'(M_PPROT), 64'(0));
    check("async_rst_pready", 64'(S_PREADY), 64'(0));
    S_PSELx = 1'b0; S_PENABLE = 1'b0; hang_cfg = 1'b0;
    @(posedge PCLK) #1;
    PRESETn = 1'b1;

    // Clean transfer after reset.
    xfer(1'b0, 32'h0000_0070, 32'h0, 4'h0, 3'b000, 32'h7777_0070, 1'b0, 0, 1'b0);
    go_idle();

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
